// File: rtl/tn_bus_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states,
// requester identities and the default RAM word-address width.
package tn_bus_pkg;

  localparam int DEFAULT_AW = 10;

  typedef enum logic [2:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    ACK_I,
    ACK_D
  } state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_t;

endpackage

// File: rtl/tn_mem_arbiter_if.sv
// CPU ibus/dbus request ports plus single-port RAM command port, as seen
// by the arbiter (slave) and by the CPU/RAM side (master).
interface tn_mem_arbiter_if #(
  parameter int AW = tn_bus_pkg::DEFAULT_AW
);

  logic [31:0]   i_ibus_adr;
  logic          i_ibus_cyc;
  logic [31:0]   o_ibus_rdt;
  logic          o_ibus_ack;

  logic [31:0]   i_dbus_adr;
  logic [31:0]   i_dbus_dat;
  logic [3:0]    i_dbus_sel;
  logic          i_dbus_we;
  logic          i_dbus_cyc;
  logic [31:0]   o_dbus_rdt;
  logic          o_dbus_ack;

  logic [AW-1:0] o_mem_addr;
  logic          o_mem_ce;
  logic          o_mem_we;
  logic [3:0]    o_mem_sel;
  logic [31:0]   o_mem_wdata;
  logic [31:0]   i_mem_rdata;

  modport slave (
    input  i_ibus_adr, i_ibus_cyc,
    input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
    input  i_mem_rdata,
    output o_ibus_rdt, o_ibus_ack,
    output o_dbus_rdt, o_dbus_ack,
    output o_mem_addr, o_mem_ce, o_mem_we, o_mem_sel, o_mem_wdata
  );

  modport master (
    output i_ibus_adr, i_ibus_cyc,
    output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
    output i_mem_rdata,
    input  o_ibus_rdt, o_ibus_ack,
    input  o_dbus_rdt, o_dbus_ack,
    input  o_mem_addr, o_mem_ce, o_mem_we, o_mem_sel, o_mem_wdata
  );

endinterface

// File: rtl/tn_arb_pick.sv
// Two-way requester pick: a lone requester wins, simultaneous requests go
// to whichever requester was not granted last.
module tn_arb_pick
  import tn_bus_pkg::*;
(
  input  logic ibus_cyc,
  input  logic dbus_cyc,
  input  req_t last_grant,
  output req_t winner
);

  always_comb begin
    // NOTE: default first so every path assigns winner and no latch is inferred.
    winner = REQ_D;
    if (ibus_cyc && dbus_cyc) begin
      winner = (last_grant == REQ_D) ? REQ_I : REQ_D;
    end else if (ibus_cyc) begin
      winner = REQ_I;
    end
  end

endmodule

// File: rtl/tn_mem_arbiter.sv
// Shares one single-port synchronous RAM between CPU ibus and dbus, one access
// in flight, fixed 2-cycle latency. Define ARB_ROUND_ROBIN_EN for fair arbitration.
module tn_mem_arbiter
  import tn_bus_pkg::*;
#(
  parameter int AW = DEFAULT_AW
) (
  input logic             clk,
  input logic             resetn,
  tn_mem_arbiter_if.slave bus
);

  state_t        state;
  req_t          last_grant;
  req_t          winner;
  logic          any_cyc;
  logic          ibus_ack_q;
  logic          dbus_ack_q;
  logic          mem_ce_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [3:0]    mem_sel_q;
  logic [31:0]   mem_wdata_q;

  assign any_cyc = bus.i_ibus_cyc || bus.i_dbus_cyc;

`ifdef ARB_ROUND_ROBIN_EN
  req_t last_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q <= REQ_I;
    end else if (state == IDLE && any_cyc) begin
      last_q <= winner;
    end
  end

  assign last_grant = last_q;
`else
  // A permanent "ibus was last" makes the picker hand every tie to dbus.
  assign last_grant = REQ_I;
`endif

  tn_arb_pick u_pick (
    .ibus_cyc   (bus.i_ibus_cyc),
    .dbus_cyc   (bus.i_dbus_cyc),
    .last_grant (last_grant),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      ibus_ack_q  <= 1'b0;
      dbus_ack_q  <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_sel_q   <= '0;
      mem_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      mem_ce_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_cyc) begin
            mem_ce_q <= 1'b1;
            if (winner == REQ_D) begin
              state       <= GRANT_D;
              mem_addr_q  <= bus.i_dbus_adr[AW+1:2];
              mem_we_q    <= bus.i_dbus_we;
              mem_sel_q   <= bus.i_dbus_sel;
              mem_wdata_q <= bus.i_dbus_dat;
            end else begin
              state      <= GRANT_I;
              mem_addr_q <= bus.i_ibus_adr[AW+1:2];
              mem_sel_q  <= 4'hF;
            end
          end
        end
        GRANT_I: begin
          state      <= ACK_I;
          ibus_ack_q <= 1'b1;
        end
        GRANT_D: begin
          state      <= ACK_D;
          dbus_ack_q <= 1'b1;
        end
        ACK_I: begin
          state      <= IDLE;
          ibus_ack_q <= 1'b0;
        end
        ACK_D: begin
          state      <= IDLE;
          dbus_ack_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM data only arrives in the ack cycle, so read data is steered, not registered.
  assign bus.o_ibus_rdt  = ibus_ack_q ? bus.i_mem_rdata : '0;
  assign bus.o_dbus_rdt  = dbus_ack_q ? bus.i_mem_rdata : '0;
  assign bus.o_ibus_ack  = ibus_ack_q;
  assign bus.o_dbus_ack  = dbus_ack_q;
  assign bus.o_mem_ce    = mem_ce_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_sel   = mem_sel_q;
  assign bus.o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_tn_mem_arbiter.sv
// Bench for tn_mem_arbiter: directed vector table, corner-case sequences and
// random traffic checked against a transaction-level arbitration model.
module tb_tn_mem_arbiter;
  import tn_bus_pkg::*;

  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk;
  logic resetn;

  tn_mem_arbiter_if #(.AW(AW)) bus ();

  tn_mem_arbiter #(.AW(AW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Initial RAM image, with a few words pinned for the directed vectors.
  function automatic logic [31:0] init_word(input int i);
    case (i)
      1:       return 32'hCAFE_0001;
      2:       return 32'h1122_3344;
      5:       return 32'h0000_0013;
      default: return 32'h5EED_0000 ^ (i * 32'h0001_0101);
    endcase
  endfunction

  // Synchronous single-port RAM attached to the arbiter.
  logic [31:0] ram [0:WORDS-1];
  logic [31:0] ram_rdata;
  assign bus.i_mem_rdata = ram_rdata;

  always @(posedge clk) begin
    if (bus.o_mem_ce) begin
      if (bus.o_mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.o_mem_sel[b]) ram[bus.o_mem_addr][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram[bus.o_mem_addr];
      end
    end
  end

  // Reference model: one transaction at a time, granted when cyc is seen while
  // free, acked one edge later, then two edges of deafness before the next look.
  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          word;
  } txn_t;

  logic [31:0] ref_mem [0:WORDS-1];
  txn_t        m_txn, e_txn, e_ack_txn;
  logic        m_pend;
  int          m_quiet;
  req_t        m_last;
  logic        e_ce, e_ack_i, e_ack_d;
  logic [31:0] e_rdt;

  task automatic m_reset();
    m_pend  = 1'b0;
    m_quiet = 0;
    m_last  = REQ_I;
    e_ce    = 1'b0;
    e_ack_i = 1'b0;
    e_ack_d = 1'b0;
    e_rdt   = '0;
  endtask

  initial begin
    logic d_wins;
    m_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_reset();
      end else begin
        e_ack_i = 1'b0;
        e_ack_d = 1'b0;
        e_ce    = 1'b0;
        if (m_pend) begin
          if (m_txn.we) begin
            for (int b = 0; b < 4; b++)
              if (m_txn.sel[b]) ref_mem[m_txn.word][8*b +: 8] = m_txn.dat[8*b +: 8];
          end else begin
            e_rdt = ref_mem[m_txn.word];
          end
          e_ack_i   = !m_txn.is_d;
          e_ack_d   = m_txn.is_d;
          e_ack_txn = m_txn;
          m_pend    = 1'b0;
        end
        if (m_quiet > 0) begin
          m_quiet--;
        end else if (bus.i_ibus_cyc || bus.i_dbus_cyc) begin
          if (bus.i_ibus_cyc && bus.i_dbus_cyc) d_wins = RR_EN ? (m_last == REQ_I) : 1'b1;
          else                                   d_wins = bus.i_dbus_cyc;
          m_txn.is_d = d_wins;
          m_txn.we   = d_wins ? bus.i_dbus_we : 1'b0;
          m_txn.sel  = d_wins ? bus.i_dbus_sel : 4'hF;
          m_txn.dat  = bus.i_dbus_dat;
          m_txn.word = int'(((d_wins ? bus.i_dbus_adr : bus.i_ibus_adr) >> 2) % WORDS);
          m_last     = d_wins ? REQ_D : REQ_I;
          m_pend     = 1'b1;
          m_quiet    = 2;
          e_ce       = 1'b1;
          e_txn      = m_txn;
        end
      end
    end
  end

  // Every out-of-reset cycle is compared with the model, mid-cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (resetn) begin
        check("model.ack_i", bus.o_ibus_ack, e_ack_i);
        check("model.ack_d", bus.o_dbus_ack, e_ack_d);
        check("model.ce", bus.o_mem_ce, e_ce);
        if (e_ce) begin
          check("model.addr", bus.o_mem_addr, e_txn.word);
          check("model.we", bus.o_mem_we, e_txn.we);
          check("model.sel", bus.o_mem_sel, e_txn.sel);
          if (e_txn.we) check("model.wdata", bus.o_mem_wdata, e_txn.dat);
        end
        if (e_ack_i) check("model.rdt_i", bus.o_ibus_rdt, e_rdt);
        if (e_ack_d && !e_ack_txn.we) check("model.rdt_d", bus.o_dbus_rdt, e_rdt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic drive_req(input logic is_d, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we);
    if (is_d) begin
      bus.i_dbus_cyc = 1'b1;
      bus.i_dbus_adr = adr;
      bus.i_dbus_dat = dat;
      bus.i_dbus_sel = sel;
      bus.i_dbus_we  = we;
    end else begin
      bus.i_ibus_cyc = 1'b1;
      bus.i_ibus_adr = adr;
    end
  endtask

  task automatic release_req();
    bus.i_ibus_cyc = 1'b0;
    bus.i_dbus_cyc = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ack_i"}, bus.o_ibus_ack, 0);
    check({tag, ".ack_d"}, bus.o_dbus_ack, 0);
    check({tag, ".ce"}, bus.o_mem_ce, 0);
    check({tag, ".we"}, bus.o_mem_we, 0);
    check({tag, ".addr"}, bus.o_mem_addr, 0);
    check({tag, ".sel"}, bus.o_mem_sel, 0);
    check({tag, ".wdata"}, bus.o_mem_wdata, 0);
    check({tag, ".rdt_i"}, bus.o_ibus_rdt, 0);
    check({tag, ".rdt_d"}, bus.o_dbus_rdt, 0);
  endtask

  typedef struct {
    string         name;
    logic          is_d;
    logic [31:0]   adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          we;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_rdt;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  vec_t v;
  req_t got_who [$];
  int   got_at  [$];
  req_t exp_who;

  initial begin
    vecs[0] = '{"ifetch_w5",   1'b0, 32'h0000_0014, 32'h0,         4'hF,    1'b0, 10'd5,    32'h0000_0013};
    vecs[1] = '{"dwr_byte1",   1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'b0010, 1'b1, 10'd2,    32'h0};
    vecs[2] = '{"drd_w2",      1'b1, 32'h0000_0008, 32'h0,         4'hF,    1'b0, 10'd2,    32'h1122_CC44};
    vecs[3] = '{"ifetch_wrap", 1'b0, 32'h0000_1004, 32'h0,         4'hF,    1'b0, 10'd1,    32'hCAFE_0001};
    vecs[4] = '{"dwr_top",     1'b1, 32'h0000_0FFC, 32'h5A5A_5A5A, 4'hF,    1'b1, 10'd1023, 32'h0};
    vecs[5] = '{"ifetch_top",  1'b0, 32'h0000_2FFC, 32'h0,         4'hF,    1'b0, 10'd1023, 32'h5A5A_5A5A};
    vecs[6] = '{"drd_lowbits", 1'b1, 32'h0000_0007, 32'h0,         4'hF,    1'b0, 10'd1,    32'hCAFE_0001};

    for (int i = 0; i < WORDS; i++) begin
      ram[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    ram_rdata      = '0;
    resetn         = 1'b0;
    bus.i_ibus_adr = '0;
    bus.i_ibus_cyc = 1'b0;
    bus.i_dbus_adr = '0;
    bus.i_dbus_dat = '0;
    bus.i_dbus_sel = '0;
    bus.i_dbus_we  = 1'b0;
    bus.i_dbus_cyc = 1'b0;

    // Reset state, with a request already pending.
    drive_req(1'b0, 32'h14, 32'h0, 4'hF, 1'b0);
    repeat (3) tick();
    check_all_zero("reset");
    release_req();
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Directed single-requester vectors.
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive_req(v.is_d, v.adr, v.dat, v.sel, v.we);
      tick();
      release_req();
      check({v.name, ".ce"}, bus.o_mem_ce, 1);
      check({v.name, ".addr"}, bus.o_mem_addr, v.exp_addr);
      check({v.name, ".we"}, bus.o_mem_we, v.is_d ? v.we : 1'b0);
      check({v.name, ".sel"}, bus.o_mem_sel, v.is_d ? v.sel : 4'hF);
      if (v.we) check({v.name, ".wdata"}, bus.o_mem_wdata, v.dat);
      check({v.name, ".early_ack"}, {bus.o_ibus_ack, bus.o_dbus_ack}, 2'b00);
      tick();
      check({v.name, ".ack"}, {bus.o_ibus_ack, bus.o_dbus_ack}, v.is_d ? 2'b01 : 2'b10);
      check({v.name, ".ce_off"}, bus.o_mem_ce, 0);
      if (!v.we) check({v.name, ".rdt"}, v.is_d ? bus.o_dbus_rdt : bus.o_ibus_rdt, v.exp_rdt);
      tick();
      check({v.name, ".ack_once"}, {bus.o_ibus_ack, bus.o_dbus_ack}, 2'b00);
    end

    // Both requesters held high: grant order and ack spacing.
    drive_req(1'b0, 32'h14, 32'h0, 4'hF, 1'b0);
    drive_req(1'b1, 32'h08, 32'h0, 4'hF, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (bus.o_ibus_ack) begin got_who.push_back(REQ_I); got_at.push_back(c); end
      if (bus.o_dbus_ack) begin got_who.push_back(REQ_D); got_at.push_back(c); end
    end
    release_req();
    repeat (4) tick();
    check("simul.n_acks", got_who.size() >= 4, 1);
    for (int k = 0; k < 4; k++) begin
      if (k < got_who.size()) begin
        exp_who = RR_EN ? ((k % 2 == 0) ? REQ_I : REQ_D) : REQ_D;
        check("simul.who", got_who[k], exp_who);
        if (k > 0) check("simul.spacing", got_at[k] - got_at[k-1], 3);
      end
    end

    // cyc still high in the ack cycle must not be re-granted.
    drive_req(1'b0, 32'h18, 32'h0, 4'hF, 1'b0);
    tick();
    check("stale.ce", bus.o_mem_ce, 1);
    tick();
    check("stale.ack", bus.o_ibus_ack, 1);
    tick();
    check("stale.no_ce_in_idle", bus.o_mem_ce, 0);
    release_req();
    tick();
    check("stale.no_regrant", bus.o_mem_ce, 0);
    tick();
    check("stale.no_ack", bus.o_ibus_ack, 0);

    // Reset during GRANT_D discards the write; a fresh fetch then completes.
    drive_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
    tick();
    check("rst_mid.ce", bus.o_mem_ce, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("rst_mid");
    release_req();
    tick();
    check("rst_mid.no_ack", bus.o_dbus_ack, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    drive_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    tick();
    release_req();
    check("rst_after.ce", bus.o_mem_ce, 1);
    tick();
    check("rst_after.ack", bus.o_ibus_ack, 1);
    check("rst_after.rdt", bus.o_ibus_rdt, init_word(4));
    repeat (2) tick();

    // Random traffic, including withdrawn requests, against the model.
    for (int c = 0; c < 500; c++) begin
      bus.i_ibus_cyc = ($urandom_range(0, 2) == 0);
      bus.i_dbus_cyc = ($urandom_range(0, 2) == 0);
      bus.i_ibus_adr = $urandom_range(0, 1) ? $urandom() : 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      bus.i_dbus_adr = $urandom_range(0, 1) ? $urandom() : 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      bus.i_dbus_dat = $urandom();
      bus.i_dbus_sel = 4'($urandom_range(0, 15));
      bus.i_dbus_we  = 1'($urandom_range(0, 1));
      tick();
    end
    release_req();
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tn_mem_arbiter.md
TN_MEM_ARBITER -- requirements
Module: tn_mem_arbiter

Interface
REQ-001 Parameter AW, default 10, word-address width of the shared memory (2^AW 32-bit words).
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 i_ibus_adr / i_ibus_cyc  input  32 / 1  CPU instruction fetch request (read-only).
REQ-005 o_ibus_rdt / o_ibus_ack  output  32 / 1  fetch data and one-cycle acknowledge.
REQ-006 i_dbus_adr / i_dbus_dat / i_dbus_sel / i_dbus_we / i_dbus_cyc  input  32 / 32 / 4 / 1 / 1  CPU data request.
REQ-007 o_dbus_rdt / o_dbus_ack  output  32 / 1  data read result and one-cycle acknowledge.
REQ-008 o_mem_addr / o_mem_ce / o_mem_we / o_mem_sel / o_mem_wdata  output  AW / 1 / 1 / 4 / 32  single-port synchronous RAM command.
REQ-009 i_mem_rdata  input  32  RAM read data, valid one cycle after o_mem_ce with o_mem_we low.

Function
REQ-010 The block SHALL share one single-port RAM between ibus and dbus, with exactly one access in flight.
REQ-011 FSM states SHALL be IDLE, GRANT_I, GRANT_D, ACK_I, ACK_D.
REQ-012 IDLE: if any cyc is high at a clock edge, the block SHALL enter GRANT_I or GRANT_D per REQ-021/REQ-022; otherwise it SHALL stay in IDLE.
REQ-013 GRANT_x: the block SHALL drive o_mem_ce=1, o_mem_addr=adr[AW+1:2], and for dbus o_mem_we=i_dbus_we, o_mem_sel=i_dbus_sel, o_mem_wdata=i_dbus_dat; next state ACK_x.
REQ-014 ACK_x: the block SHALL assert x_ack for exactly one cycle, present o_x_rdt=i_mem_rdata, and return to IDLE.
REQ-015 Latency SHALL be fixed: cyc sampled at edge N, ack high in cycle N+2, for reads and writes.
REQ-016 Outside GRANT states, o_mem_ce and o_mem_we SHALL be 0; o_mem_sel SHALL be 4'hF on ibus grants.
REQ-017 A dbus write ack SHALL drive o_dbus_rdt = i_mem_rdata; software ignores it.
REQ-018 Address bits above AW+1 and bits [1:0] SHALL be ignored, so accesses wrap modulo 2^AW words.
REQ-019 A cyc that drops before its grant SHALL be treated as withdrawn; a cyc that drops during GRANT_x/ACK_x SHALL NOT abort the access.
REQ-020 Requester cyc SHALL be sampled only in IDLE, so a cyc still high in the ACK cycle is not re-granted.

Reset
REQ-023 On resetn low the block SHALL asynchronously enter IDLE with o_ibus_ack=0, o_dbus_ack=0, o_mem_ce=0, o_mem_we=0, o_mem_addr=0, o_mem_sel=0, o_mem_wdata=0, o_ibus_rdt=0, o_dbus_rdt=0, and round-robin pointer = ibus-last.
REQ-024 Reset asserted mid-access SHALL discard the access without ack; after release the block SHALL restart from IDLE.

Configuration
REQ-021 With ARB_ROUND_ROBIN_EN defined, simultaneous ibus and dbus requests SHALL be granted to the requester not granted last, and every grant SHALL update the pointer.
REQ-022 Without ARB_ROUND_ROBIN_EN, dbus SHALL always win simultaneous requests, and the pointer SHALL not exist.

Structure
REQ-025 Package tn_bus_pkg SHALL hold the FSM state enum, the requester enum (REQ_I, REQ_D) and the default AW constant.
REQ-026 The two-way pick logic SHALL be a sub-module tn_arb_pick (inputs: both cyc and last-grant; output: winner).

Verification
REQ-027 ibus-only read: mem[5]=32'h00000013, ibus_adr=0x14 at edge 0 -> o_mem_ce and o_mem_addr=5 in cycle 1; o_ibus_ack=1 and rdt=32'h00000013 in cycle 2 only.
REQ-028 dbus byte write: adr=0x8, dat=32'hAABBCCDD, sel=4'b0010, we=1 -> o_mem_we=1, sel=4'b0010 in cycle 1, dbus_ack in cycle 2; a later read of word 2 returns only byte 1 = 0xCC changed.
REQ-029 Simultaneous cyc, held high: with ARB_ROUND_ROBIN_EN, grants alternate I,D,I,D with ack spacing of 3 cycles; without it, dbus is granted first every time.
REQ-030 Wrap: ibus_adr=32'h00001004 with AW=10 -> o_mem_addr=1.
REQ-031 Reset mid-access: drop resetn in a GRANT_D cycle -> all outputs 0 immediately, no ack; after release a new ibus request completes in 2 cycles.
REQ-032 Stale cyc: requester keeps cyc high one cycle after ack -> no second grant until the cycle after IDLE is re-entered.
